sisc_exec_ctrl: RTL and testbench

SISC_EXEC_CTRL -- requirements
Module: sisc_exec_ctrl

---
 rtl/sisc_pkg.sv | 52 +++++
 rtl/sisc_alu.sv | 46 ++++
 rtl/sisc_exec_ctrl.sv | 126 ++++++++++++
 tb/tb_sisc_exec_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC execution controller: opcodes, ALU ops, FSM states, flag bit positions.
package sisc_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_RTYPE = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_BRA   = 4'b0100;
  localparam logic [3:0] OP_BRR   = 4'b1000;
  localparam logic [3:0] OP_HLT   = 4'b1111;

  localparam logic [3:0] MM_ADD = 4'b0000;
  localparam logic [3:0] MM_SUB = 4'b0001;
  localparam logic [3:0] MM_AND = 4'b0010;

  localparam int CC_C = 3;
  localparam int CC_N = 2;
  localparam int CC_V = 1;
  localparam int CC_Z = 0;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_ADDI = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_AND  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  function automatic logic is_alu_instr(input logic [3:0] opcode, input logic [3:0] mm);
    return (opcode == OP_ADDI) ||
           ((opcode == OP_RTYPE) && (mm == MM_ADD || mm == MM_SUB || mm == MM_AND));
  endfunction

  function automatic logic [1:0] alu_op_of(input logic [3:0] opcode, input logic [3:0] mm);
    logic [1:0] op;
    op = ALU_ADD;
    if (opcode == OP_ADDI) op = ALU_ADDI;
    else if (mm == MM_SUB) op = ALU_SUB;
    else if (mm == MM_AND) op = ALU_AND;
    return op;
  endfunction

endpackage

// File: rtl/sisc_alu.sv
// Combinational 32-bit ALU with {C,N,V,Z} flags. Subtract runs through the adder as a + ~b + 1,
// so C reads as "no borrow".
module sisc_alu
  import sisc_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  input  logic [15:0] imm,
  output logic [31:0] result,
  output logic [3:0]  cc
);

  logic [31:0] opb;
  logic        cin;
  logic [32:0] sum;

  always_comb begin
    opb = rsb;
    cin = 1'b0;
    case (alu_op)
      ALU_ADDI: opb = {{16{imm[15]}}, imm};
      ALU_SUB: begin
        opb = ~rsb;
        cin = 1'b1;
      end
      default: opb = rsb;
    endcase
    sum = {1'b0, rsa} + {1'b0, opb} + {32'd0, cin};
  end

  always_comb begin
    cc = 4'b0000;
    if (alu_op == ALU_AND) begin
      result   = rsa & rsb;
    end else begin
      result   = sum[31:0];
      cc[CC_C] = sum[32];
      // overflow: both addends share a sign that the result does not
      cc[CC_V] = (rsa[31] == opb[31]) && (result[31] != rsa[31]);
    end
    cc[CC_N] = result[31];
    cc[CC_Z] = (result == 32'd0);
  end

endmodule

// File: rtl/sisc_exec_ctrl.sv
// Multi-cycle execution controller for the SISC core: sequencing FSM, branch target adder, ALU.
// Only the FSM state is registered; all control outputs decode from state, instr and stat.
//
//   state     | meaning
//   START0    | PC held in reset
//   START1    | settle, all outputs idle
//   FETCH     | PC advances to pc_inc
//   DECODE    | branch resolution, PC loads br_addr when taken
//   EXECUTE   | ALU operation, flag register write
//   MEM       | idle slot
//   WRITEBACK | ALU result written to rd (R-type) or rt (ADDI)
//   HALT      | stopped until reset
module sisc_exec_ctrl
  import sisc_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_F,
  input  logic [31:0] instr,
  input  logic [3:0]  stat,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  input  logic [15:0] pc_inc,
  output logic [31:0] alu_result,
  output logic [3:0]  cc,
  output logic        stat_en,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        rd_sel,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        pc_rst,
  output logic        br_sel,
  output logic [15:0] br_addr
);

  state_t      state;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic        alu_valid;
  logic        is_branch;
  logic        br_taken;
  logic        unused_fields;

  assign opcode        = instr[31:28];
  assign mm            = instr[27:24];
  assign imm           = instr[15:0];
  assign unused_fields = ^instr[23:16];

  assign alu_valid = is_alu_instr(opcode, mm);
  assign is_branch = (opcode == OP_BRA) || (opcode == OP_BRR);
  assign br_taken  = (mm == 4'b0000) || ((mm & stat) != 4'b0000);

  assign br_sel  = (opcode == OP_BRA);
  assign br_addr = br_sel ? imm : (pc_inc + imm);

  always_ff @(posedge CLK) begin
    if (RST_F) begin
      state <= S_START0;
    end else begin
      case (state)
        S_START0:    state <= S_START1;
        S_START1:    state <= S_FETCH;
        S_FETCH:     state <= S_DECODE;
        S_DECODE:    state <= (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
        S_EXECUTE:   state <= S_MEM;
        S_MEM:       state <= S_WRITEBACK;
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_START0;
      endcase
    end
  end

  // Reset is also applied combinationally so outputs are safe before the first edge.
  always_comb begin
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rd_sel   = 1'b0;
    stat_en  = 1'b0;
    alu_op   = ALU_ADD;
    if (RST_F) begin
      pc_rst = 1'b1;
    end else begin
      case (state)
        S_START0: pc_rst   = 1'b1;
        S_FETCH:  pc_write = 1'b1;
        S_DECODE: begin
          if (is_branch && br_taken) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
          end
        end
        S_EXECUTE: begin
          if (alu_valid) begin
            stat_en = 1'b1;
            alu_op  = alu_op_of(opcode, mm);
          end
        end
        S_WRITEBACK: begin
          if (alu_valid) begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
            rd_sel = (opcode == OP_RTYPE);
            alu_op = alu_op_of(opcode, mm);
          end
        end
        default: ;
      endcase
    end
  end

  sisc_alu u_alu (
    .alu_op (alu_op),
    .rsa    (rsa),
    .rsb    (rsb),
    .imm    (imm),
    .result (alu_result),
    .cc     (cc)
  );

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Scoreboard bench for sisc_exec_ctrl: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares.
module tb_sisc_exec_ctrl;

  logic        CLK;
  logic        RST_F;
  logic [31:0] instr;
  logic [3:0]  stat;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [15:0] pc_inc;
  logic [31:0] alu_result;
  logic [3:0]  cc;
  logic        stat_en;
  logic [1:0]  alu_op;
  logic        rf_we;
  logic        wb_sel;
  logic        rd_sel;
  logic        pc_write;
  logic        pc_sel;
  logic        pc_rst;
  logic        br_sel;
  logic [15:0] br_addr;

  sisc_exec_ctrl dut (
    .CLK        (CLK),
    .RST_F      (RST_F),
    .instr      (instr),
    .stat       (stat),
    .rsa        (rsa),
    .rsb        (rsb),
    .pc_inc     (pc_inc),
    .alu_result (alu_result),
    .cc         (cc),
    .stat_en    (stat_en),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .rd_sel     (rd_sel),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .pc_rst     (pc_rst),
    .br_sel     (br_sel),
    .br_addr    (br_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ctl = {pc_rst, pc_write, pc_sel, rf_we, wb_sel, rd_sel, stat_en, alu_op[1:0]}
  localparam logic [8:0] C_RST    = 9'b100_000_0_00;
  localparam logic [8:0] C_IDLE   = 9'b000_000_0_00;
  localparam logic [8:0] C_FETCH  = 9'b010_000_0_00;
  localparam logic [8:0] C_BR     = 9'b011_000_0_00;
  localparam logic [8:0] C_EX_ADD = 9'b000_000_1_00;
  localparam logic [8:0] C_WB_ADD = 9'b000_111_0_00;
  localparam logic [8:0] C_EX_SUB = 9'b000_000_1_10;
  localparam logic [8:0] C_WB_SUB = 9'b000_111_0_10;
  localparam logic [8:0] C_EX_AND = 9'b000_000_1_11;
  localparam logic [8:0] C_WB_AND = 9'b000_111_0_11;
  localparam logic [8:0] C_EX_ADI = 9'b000_000_1_01;
  localparam logic [8:0] C_WB_ADI = 9'b000_110_0_01;

  typedef struct {
    string       nm;
    logic [8:0]  ctl;
    bit          ca;
    logic [31:0] res;
    logic [3:0]  ccx;
    bit          cb;
    logic [15:0] bra;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic [8:0] act_ctl;

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      act_ctl = {pc_rst, pc_write, pc_sel, rf_we, wb_sel, rd_sel, stat_en, alu_op};
      n_vec++;
      if (act_ctl !== mon_e.ctl) begin
        n_err++;
        $display("FAIL %s ctl: got %b expected %b", mon_e.nm, act_ctl, mon_e.ctl);
      end
      if (mon_e.ca) begin
        n_vec++;
        if (alu_result !== mon_e.res || cc !== mon_e.ccx) begin
          n_err++;
          $display("FAIL %s alu: got %h/%b expected %h/%b", mon_e.nm, alu_result, cc,
                   mon_e.res, mon_e.ccx);
        end
      end
      if (mon_e.cb) begin
        n_vec++;
        if (br_addr !== mon_e.bra) begin
          n_err++;
          $display("FAIL %s br_addr: got %h expected %h", mon_e.nm, br_addr, mon_e.bra);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [8:0] ctl, input bit ca,
                      input logic [31:0] res, input logic [3:0] ccx,
                      input bit cb, input logic [15:0] bra);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.ca = ca; e.res = res; e.ccx = ccx; e.cb = cb; e.bra = bra;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_instr(input string nm, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] pci, input logic [3:0] st,
                           input logic [8:0] dec, input logic [8:0] exe, input logic [8:0] wb,
                           input bit ca, input logic [31:0] res, input logic [3:0] ccx,
                           input bit cb, input logic [15:0] bra);
    instr = ins; rsa = a; rsb = b; pc_inc = pci; stat = st;
    step({nm, "/fetch"},  C_FETCH, 0, '0, '0, 0, '0);
    step({nm, "/decode"}, dec,     0, '0, '0, cb, bra);
    step({nm, "/exec"},   exe,     ca, res, ccx, 0, '0);
    step({nm, "/mem"},    C_IDLE,  0, '0, '0, 0, '0);
    step({nm, "/wb"},     wb,      ca, res, ccx, 0, '0);
  endtask

  task automatic restart(input string nm);
    RST_F = 1'b1;
    step({nm, "/rst_a"}, C_RST, 0, '0, '0, 0, '0);
    step({nm, "/rst_b"}, C_RST, 0, '0, '0, 0, '0);
    RST_F = 1'b0;
    step({nm, "/start0"}, C_RST,  0, '0, '0, 0, '0);
    step({nm, "/start1"}, C_IDLE, 0, '0, '0, 0, '0);
  endtask

  initial begin
    RST_F = 1'b1; instr = '0; stat = '0; rsa = '0; rsb = '0; pc_inc = '0;
    @(posedge CLK);
    #1;
    restart("boot");

    run_instr("add",  32'h10123000, 32'h0F0F0F0F, 32'h00000003, 16'h0000, 4'h0,
              C_IDLE, C_EX_ADD, C_WB_ADD, 1, 32'h0F0F0F12, 4'b0000, 0, '0);
    run_instr("sub0", 32'h11123000, 32'h00000005, 32'h00000005, 16'h0000, 4'h0,
              C_IDLE, C_EX_SUB, C_WB_SUB, 1, 32'h00000000, 4'b1001, 0, '0);
    run_instr("addi_ovf", 32'h20120001, 32'h7FFFFFFF, 32'h12345678, 16'h0000, 4'h0,
              C_IDLE, C_EX_ADI, C_WB_ADI, 1, 32'h80000000, 4'b0110, 0, '0);
    run_instr("addi_neg", 32'h2012FFFF, 32'h00000000, 32'h00000009, 16'h0000, 4'h0,
              C_IDLE, C_EX_ADI, C_WB_ADI, 1, 32'hFFFFFFFF, 4'b0100, 0, '0);
    run_instr("and",  32'h12123000, 32'hF0F0FFFF, 32'h8F0F0001, 16'h0000, 4'h0,
              C_IDLE, C_EX_AND, C_WB_AND, 1, 32'h80000001, 4'b0100, 0, '0);
    run_instr("sub_borrow", 32'h11123000, 32'h00000003, 32'h00000005, 16'h0000, 4'h0,
              C_IDLE, C_EX_SUB, C_WB_SUB, 1, 32'hFFFFFFFE, 4'b0100, 0, '0);
    run_instr("sub_ovf", 32'h11123000, 32'h80000000, 32'h00000001, 16'h0000, 4'h0,
              C_IDLE, C_EX_SUB, C_WB_SUB, 1, 32'h7FFFFFFF, 4'b1010, 0, '0);
    run_instr("add_wrap", 32'h10123000, 32'hFFFFFFFF, 32'h00000001, 16'h0000, 4'h0,
              C_IDLE, C_EX_ADD, C_WB_ADD, 1, 32'h00000000, 4'b1001, 0, '0);
    run_instr("rtype_nop", 32'h13123000, 32'h00000001, 32'h00000001, 16'h0000, 4'h0,
              C_IDLE, C_IDLE, C_IDLE, 0, '0, '0, 0, '0);
    run_instr("brr_taken", 32'h8100FFFE, 32'h0, 32'h0, 16'h0010, 4'b0001,
              C_BR, C_IDLE, C_IDLE, 0, '0, '0, 1, 16'h000E);
    run_instr("brr_not", 32'h8100FFFE, 32'h0, 32'h0, 16'h0010, 4'b0000,
              C_IDLE, C_IDLE, C_IDLE, 0, '0, '0, 1, 16'h000E);
    run_instr("bra_uncond", 32'h40001234, 32'h0, 32'h0, 16'h0010, 4'b0000,
              C_BR, C_IDLE, C_IDLE, 0, '0, '0, 1, 16'h1234);

    // mid-instruction reset during EXECUTE
    instr = 32'h10123000; rsa = 32'h1; rsb = 32'h2; stat = 4'h0;
    step("midrst/fetch",  C_FETCH, 0, '0, '0, 0, '0);
    step("midrst/decode", C_IDLE,  0, '0, '0, 0, '0);
    step("midrst/exec",   C_EX_ADD, 1, 32'h00000003, 4'b0000, 0, '0);
    restart("midrst");

    instr = 32'hF0000000;
    step("hlt/fetch",  C_FETCH, 0, '0, '0, 0, '0);
    step("hlt/decode", C_IDLE,  0, '0, '0, 0, '0);
    instr = 32'h10123000;
    for (int i = 0; i < 6; i++) step("hlt/held", C_IDLE, 0, '0, '0, 0, '0);
    restart("hlt_exit");
    step("hlt_exit/fetch", C_FETCH, 0, '0, '0, 0, '0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
